rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Round-robin arbiter sharing the register file's single write port between NREQ writeback requesters (ALU, load unit, CSR unit). It grants one requester per cycle through a valid/ready handshake and registers the winning address and data onto the register-file write port with one cycle of latency. It also counts contention cycles for performance debug.

## Interface
- WIDTH, 32, data width of one register
- AW, 5, register address width
- NREQ, 3, number of requesters (2..8)
- IW, 2, width of grant index; must be at least ceil(log2(NREQ))

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  packed destination addresses; requester i occupies bits [i*AW +: AW]
- req_data  in  NREQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot grant; combinational
- stall  in  1  blocks all grants this cycle
- wr_en  out  1  register-file write enable; registered
- wr_addr  out  AW  register-file write address; registered
- wr_data  out  WIDTH  register-file write data; registered
- grant_id  out  IW  index of the last accepted requester; registered
- conflict_cnt  out  16  saturating count of contention cycles

## Operation
- **Transfer rule:** a transfer occurs on requester i when req_valid[i] and req_ready[i] are both high at a rising edge.
- **Requester obligations:** a requester holds valid, addr and data stable until its transfer. It may drop valid only after the transfer.
- **req_ready:**
  - At most one bit is high per cycle.
  - All bits are 0 when stall=1 or when no request is valid.
  - Only the winner is high; it is never high for a non-valid requester.
- **Round-robin order:** the search starts at index ptr+1 mod NREQ. The first valid index found wins.
- **Pointer update:**
  - On a transfer, ptr loads the winner's index.
  - On no transfer, ptr holds.
  - Reset value of ptr is NREQ-1, so requester 0 has first priority.
- **Output stage:** on a transfer at edge t:
  - wr_en=1, wr_addr, wr_data and grant_id take the winner's values in the cycle after t.
  - If there is no transfer at edge t+1, wr_en returns to 0 in the following cycle.
  - wr_addr, wr_data and grant_id hold their last values while wr_en=0.
- **Back-to-back:** consecutive transfers produce wr_en high on consecutive cycles, with no bubble.
- **conflict_cnt:**
  - Increments by 1 on each edge where stall=0 and two or more req_valid bits are set.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- **stall:** while high, no grants occur. The pointer, conflict_cnt and pending requests are unaffected. wr_en is 0 in the cycle after any stalled edge.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, grant_id=0, conflict_cnt=0, ptr=NREQ-1. req_ready is combinational; during reset it is forced to 0.
- Reset applied mid-operation clears all outputs immediately (asynchronous). An in-flight write (one already accepted but not yet on wr_en) is dropped.
- Reset deassertion is synchronous to clk. The first grant is possible at the first rising edge after rst goes high.
- Latency from request to write: 1 cycle from the transfer edge.
- Throughput: 1 write per cycle.
- Fairness: a continuously valid requester waits at most NREQ-1 grants.
- Simultaneous events:
  - A request arriving in the same cycle as stall deassertion is eligible that cycle.
  - A requester granted at edge t that remains valid (a new request) competes normally at t+1, after all others in round-robin order.

## Configuration
- Macro: RF_WB_X0_FILTER_EN.
- **Defined:** a transfer with address 0 completes normally (ready asserted, ptr and grant_id update) but wr_en stays 0 for it. x0 is never written.
- **Undefined:** address-0 writes are forwarded with wr_en=1 like any other address. The register file itself must then ignore them.

## Test plan
- **Reset:** rst=0 with all inputs active → wr_en=0, req_ready=0, conflict_cnt=0. Release reset, then set req_valid=3'b001, addr=5, data=32'hDEADBEEF → req_ready=3'b001. Next cycle: wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF, grant_id=0.
- **Round robin:** all three requesters valid and held for 6 cycles → grant order 0,1,2,0,1,2. wr_en stays high for 6 consecutive cycles. conflict_cnt=6.
- **Stall:** requests 3'b110 with stall=1 for 3 cycles → req_ready=0 and wr_en=0 throughout, conflict_cnt unchanged. Drop stall → requester 1 is granted first, then requester 2.
- **Reset mid-operation:** assert rst low one cycle after a transfer → wr_en=0 immediately. After release, ptr=NREQ-1, so requester 0 wins over 1 and 2.
- **x0 filter:** requester 2 writes addr 0, data 32'h1. With RF_WB_X0_FILTER_EN: req_ready[2]=1, wr_en=0, grant_id=2. Without it: wr_en=1, wr_addr=0.
- **Saturation:** two requesters held valid for 70000 cycles → conflict_cnt=16'hFFFF and holds there.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: requester and register-file write-port bus of the write arbiter
//   req_valid/req_addr/req_data/stall : requester side inputs to the arbiter
//   req_ready                         : one-hot combinational grant
//   wr_en/wr_addr/wr_data/grant_id    : registered register-file write port
//   conflict_cnt                      : saturating contention counter
interface rf_write_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int NREQ  = 3,
  parameter int IW    = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  stall;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic [IW-1:0]         grant_id;
  logic [15:0]           conflict_cnt;
  modport master (
    output req_valid, req_addr, req_data, stall,
    input  req_ready, wr_en, wr_addr, wr_data, grant_id, conflict_cnt
  );
  modport slave (
    input  req_valid, req_addr, req_data, stall,
    output req_ready, wr_en, wr_addr, wr_data, grant_id, conflict_cnt
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter for the register file's single write port
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : rf_write_arbiter_if.slave (requests in, one-hot ready, registered write port, contention count)
// Optional macro RF_WB_X0_FILTER_EN: accepted writes to address 0 keep wr_en low.
module rf_write_arbiter #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int NREQ  = 3,
  parameter int IW    = 2
) (
  input logic               clk,
  input logic               rst,
  rf_write_arbiter_if.slave bus
);
  logic [IW-1:0]    ptr_q, ptr_d, win, idx, grant_q;
  logic             found, xfer, multi, wr_en_d, wr_en_q;
  logic [AW-1:0]    win_addr, wr_addr_q;
  logic [WIDTH-1:0] win_data, wr_data_q;
  logic [15:0]      cnt_q, cnt_d;
  // First valid requester scanning upward from the one after the last winner
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign win_addr = bus.req_addr[int'(win)*AW +: AW];
  assign win_data = bus.req_data[int'(win)*WIDTH +: WIDTH];
  assign xfer = found && !bus.stall;
  // Two or more bits set: clearing the lowest set bit leaves something
  assign multi = |(bus.req_valid & (bus.req_valid - NREQ'(1)));
`ifdef RF_WB_X0_FILTER_EN
  assign wr_en_d = xfer && (win_addr != '0);
`else
  assign wr_en_d = xfer;
`endif
  assign ptr_d = xfer ? win : ptr_q;
  assign cnt_d = (!bus.stall && multi && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  assign bus.req_ready = (xfer && rst) ? NREQ'(1) << win : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= IW'(NREQ - 1);
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wr_en_q <= wr_en_d;
      cnt_q   <= cnt_d;
      if (xfer) grant_q <= win;
      if (wr_en_d) begin
        wr_addr_q <= win_addr;
        wr_data_q <= win_data;
      end
    end
  end
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.grant_id     = grant_q;
  assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: table, directed and randomized checks of rf_write_arbiter against a reference model
module tb_rf_write_arbiter;
  localparam int WIDTH = 32, AW = 5, NREQ = 3, IW = 2;
`ifdef RF_WB_X0_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  rf_write_arbiter_if #(.WIDTH(WIDTH), .AW(AW), .NREQ(NREQ), .IW(IW)) bus ();
  rf_write_arbiter #(.WIDTH(WIDTH), .AW(AW), .NREQ(NREQ), .IW(IW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  logic [AW-1:0]    a [NREQ];
  logic [WIDTH-1:0] d [NREQ];
  assign bus.req_addr = {a[2], a[1], a[0]};
  assign bus.req_data = {d[2], d[1], d[0]};
  int checks = 0, failures = 0;
  int m_ptr, m_gid, m_cnt;
  logic m_en;
  logic [AW-1:0] m_addr;
  logic [WIDTH-1:0] m_data;
  logic [NREQ-1:0] last_ready;
  typedef struct {
    logic [2:0] v;
    logic       s;
    logic [2:0] r;
    int         gid;
    logic       en;
  } vec_t;
  vec_t tbl [10];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Round-robin rule: scan upward from the requester after the last winner
  function automatic int pick();
    if (bus.stall || !rst) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      if (bus.req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction
  task automatic check_regs();
    chk("wr_en", 64'(bus.wr_en), 64'(m_en));
    chk("wr_addr", 64'(bus.wr_addr), 64'(m_addr));
    chk("wr_data", 64'(bus.wr_data), 64'(m_data));
    chk("grant_id", 64'(bus.grant_id), 64'(m_gid));
    chk("conflict_cnt", 64'(bus.conflict_cnt), 64'(m_cnt));
  endtask
  task automatic cycle();
    int w;
    bit conf;
    logic [2:0] exp_r;
    #1;
    w = pick();
    exp_r = (w < 0) ? 3'b000 : 3'(1 << w);
    last_ready = bus.req_ready;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_r));
    conf = !bus.stall && $countones(bus.req_valid) >= 2;
    @(posedge clk);
    if (w >= 0) begin
      m_ptr = w;
      m_gid = w;
      if (FILT && a[w] == '0) m_en = 1'b0;
      else begin
        m_en = 1'b1;
        m_addr = a[w];
        m_data = d[w];
      end
    end else m_en = 1'b0;
    if (conf && m_cnt < 65535) m_cnt++;
    #1;
    check_regs();
  endtask
  task automatic do_reset();
    rst = 1'b0;
    #1;
    m_ptr = NREQ - 1;
    m_gid = 0;
    m_cnt = 0;
    m_en = 1'b0;
    m_addr = '0;
    m_data = '0;
    chk("rst_ready", 64'(bus.req_ready), 64'(0));
    check_regs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask
  initial begin
    logic [NREQ-1:0] nv;
    tbl[0] = '{3'b001, 1'b0, 3'b001, 0, 1'b1};
    tbl[1] = '{3'b111, 1'b0, 3'b010, 1, 1'b1};
    tbl[2] = '{3'b111, 1'b0, 3'b100, 2, 1'b1};
    tbl[3] = '{3'b111, 1'b0, 3'b001, 0, 1'b1};
    tbl[4] = '{3'b110, 1'b1, 3'b000, 0, 1'b0};
    tbl[5] = '{3'b110, 1'b0, 3'b010, 1, 1'b1};
    tbl[6] = '{3'b110, 1'b0, 3'b100, 2, 1'b1};
    tbl[7] = '{3'b000, 1'b0, 3'b000, 2, 1'b0};
    tbl[8] = '{3'b101, 1'b0, 3'b001, 0, 1'b1};
    tbl[9] = '{3'b101, 1'b0, 3'b100, 2, 1'b1};
    for (int i = 0; i < NREQ; i++) begin
      a[i] = AW'(i + 1);
      d[i] = 32'hA0 + i;
    end
    bus.req_valid = 3'b111;
    bus.stall = 1'b0;
    last_ready = '0;
    // reset with all inputs active, then first single transfer
    do_reset();
    bus.req_valid = 3'b001;
    a[0] = 5'd5;
    d[0] = 32'hDEADBEEF;
    cycle();
    chk("first_ready", 64'(last_ready), 64'(3'b001));
    chk("first_wr_en", 64'(bus.wr_en), 64'(1));
    chk("first_addr", 64'(bus.wr_addr), 64'(5));
    chk("first_data", 64'(bus.wr_data), 64'(32'hDEADBEEF));
    chk("first_gid", 64'(bus.grant_id), 64'(0));
    // table vectors
    do_reset();
    for (int i = 0; i < NREQ; i++) a[i] = AW'(i + 1);
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = tbl[i].v;
      bus.stall = tbl[i].s;
      cycle();
      chk("tbl_ready", 64'(last_ready), 64'(tbl[i].r));
      chk("tbl_gid", 64'(bus.grant_id), 64'(tbl[i].gid));
      chk("tbl_wr_en", 64'(bus.wr_en), 64'(tbl[i].en));
    end
    chk("tbl_cnt", 64'(bus.conflict_cnt), 64'(7));
    // round robin, all requesters held valid
    do_reset();
    bus.req_valid = 3'b111;
    bus.stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_gid", 64'(bus.grant_id), 64'(i % 3));
      chk("rr_wr_en", 64'(bus.wr_en), 64'(1));
    end
    chk("rr_cnt", 64'(bus.conflict_cnt), 64'(6));
    // stall blocks grants and counting
    do_reset();
    bus.req_valid = 3'b110;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_ready", 64'(last_ready), 64'(0));
      chk("stall_wr_en", 64'(bus.wr_en), 64'(0));
      chk("stall_cnt", 64'(bus.conflict_cnt), 64'(0));
    end
    bus.stall = 1'b0;
    cycle();
    chk("unstall_gid1", 64'(bus.grant_id), 64'(1));
    cycle();
    chk("unstall_gid2", 64'(bus.grant_id), 64'(2));
    // reset right after a transfer, then requester 0 has priority again
    bus.req_valid = 3'b001;
    cycle();
    chk("pre_rst_wr_en", 64'(bus.wr_en), 64'(1));
    do_reset();
    bus.req_valid = 3'b111;
    cycle();
    chk("post_rst_ready", 64'(last_ready), 64'(3'b001));
    // address-0 write
    bus.req_valid = 3'b001;
    a[0] = 5'd7;
    cycle();
    bus.req_valid = 3'b100;
    a[2] = 5'd0;
    d[2] = 32'h1;
    cycle();
    chk("x0_ready", 64'(last_ready), 64'(3'b100));
    chk("x0_gid", 64'(bus.grant_id), 64'(2));
`ifdef RF_WB_X0_FILTER_EN
    chk("x0_wr_en", 64'(bus.wr_en), 64'(0));
    chk("x0_addr", 64'(bus.wr_addr), 64'(7));
`else
    chk("x0_wr_en", 64'(bus.wr_en), 64'(1));
    chk("x0_addr", 64'(bus.wr_addr), 64'(0));
`endif
    // randomized traffic honouring the hold-until-transfer obligation
    bus.req_valid = '0;
    for (int n = 0; n < 400; n++) begin
      nv = bus.req_valid;
      for (int i = 0; i < NREQ; i++) begin
        if (!nv[i] || last_ready[i]) begin
          nv[i] = ($urandom_range(0, 9) < 6);
          a[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
          d[i] = $urandom;
        end
      end
      bus.req_valid = nv;
      bus.stall = ($urandom_range(0, 3) == 0);
      cycle();
    end
    // saturation of the contention counter
    bus.stall = 1'b0;
    bus.req_valid = 3'b011;
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_cnt", 64'(bus.conflict_cnt), 64'(16'hFFFF));
    repeat (5) @(posedge clk);
    #1;
    chk("sat_hold", 64'(bus.conflict_cnt), 64'(16'hFFFF));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
